// File: rtl/byte_serial_adder32_pkg.sv
// Shared constants, state encoding and slice index type for the byte-serial
// 32-bit add/subtract unit.
package adder32_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = DATA_W / SLICE_W;
  localparam int IDX_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_adder32_if.sv
// Request, slice bus and result handshake bundle for byte_serial_adder32.
// The adder is the slave; the requester/consumer side is the master.
interface byte_serial_adder32_if;
  import adder32_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic               sub;

  logic               slice_valid;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  sum;
  logic               carry;
  logic               overflow;
  logic               zero;
  logic               parity;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, slice_valid, slice_a, slice_b,
    output out_valid, sum, carry, overflow, zero, parity
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, slice_valid, slice_a, slice_b,
    input  out_valid, sum, carry, overflow, zero, parity
  );

endinterface

// File: rtl/byte_serial_adder32_add_slice8.sv
// Combinational SLICE_W-bit adder with carry-in/carry-out; one instance is
// time-shared across all slices of the operand.
module add_slice8
  import adder32_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/byte_serial_adder32.sv
// Multi-cycle 32-bit add/subtract: one SLICE_W slice per cycle, LSB first,
// carry registered between slices, result returned over valid/ready.
module byte_serial_adder32
  import adder32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  byte_serial_adder32_if.slave  bus
);

  state_t state_reg, state_next;

  logic [NSLICE-1:0][SLICE_W-1:0] a_reg;
  logic [NSLICE-1:0][SLICE_W-1:0] b_reg;
  logic [NSLICE-1:0][SLICE_W-1:0] sum_reg;
  logic [NSLICE-1:0][SLICE_W-1:0] sum_next;
  logic                           c_reg;
  idx_t                           idx_reg;

  logic carry_reg, overflow_reg, zero_reg, parity_reg;

  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx_reg == idx_t'(NSLICE - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  add_slice8 u_slice (
    .x    (a_reg[idx_reg]),
    .y    (b_reg[idx_reg]),
    .cin  (c_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Only the byte under the current index takes the slice result.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_sum
      assign sum_next[gi] = (state_reg == RUN && idx_reg == idx_t'(gi)) ? slice_s : sum_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= 1'b0;
      idx_reg <= '0;
      sum_reg <= '0;
    end else if (accept) begin
      a_reg   <= bus.a;
      b_reg   <= bus.b ^ {DATA_W{bus.sub}};
      c_reg   <= bus.sub;
      idx_reg <= '0;
      sum_reg <= '0;
    end else if (state_reg == RUN) begin
      c_reg   <= slice_cout;
      sum_reg <= sum_next;
      if (!last) idx_reg <= idx_reg + idx_t'(1);
    end
  end

  // On the last slice sum_next already holds the complete result.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      parity_reg   <= 1'b0;
    end else if (last) begin
      carry_reg    <= slice_cout;
      overflow_reg <= (a_reg[NSLICE-1][SLICE_W-1] == b_reg[NSLICE-1][SLICE_W-1]) &&
                      (sum_next[NSLICE-1][SLICE_W-1] != a_reg[NSLICE-1][SLICE_W-1]);
      zero_reg     <= (sum_next == '0);
      parity_reg   <= ^sum_next;
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.slice_valid = (state_reg == RUN);
  assign bus.slice_a     = a_reg[idx_reg];
  assign bus.slice_b     = b_reg[idx_reg];
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.sum         = sum_reg;
  assign bus.carry       = carry_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.zero        = zero_reg;
  assign bus.parity      = parity_reg;

endmodule
